// File: rtl/step_sequencer.sv
// Sequences a programmable chain of start/done step units over one 8-bit operand.
// Optional cycle counter output perf_cycles is enabled by defining STEP_SEQ_PERF_EN.
module step_sequencer #(
  parameter int unsigned NUM_UNITS = 4,
  parameter int unsigned IDX_W     = 2,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned LEN_W     = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       prog_we,
  input  logic [$clog2(DEPTH)-1:0]   prog_addr,
  input  logic [IDX_W-1:0]           prog_idx,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [7:0]                 cmd_data,
  input  logic [LEN_W-1:0]           cmd_len,
  output logic [NUM_UNITS-1:0]       step_start,
  output logic [7:0]                 step_in_data,
  input  logic [NUM_UNITS-1:0]       step_done,
  input  logic [8*NUM_UNITS-1:0]     step_out_data,
  output logic                       res_valid,
  output logic [7:0]                 res_data,
  output logic                       res_err,
  output logic                       busy
`ifdef STEP_SEQ_PERF_EN
  ,
  output logic [15:0]                perf_cycles
`endif
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                 state, state_d;
  logic [IDX_W-1:0]       prog [DEPTH];
  logic [7:0]             acc, acc_d;
  logic [LEN_W-1:0]       len, len_d;
  logic [ADDR_W-1:0]      ptr, ptr_d;
  logic [IDX_W-1:0]       cur_idx, cur_idx_d;
  logic [TMR_W-1:0]       timer, timer_d;
  logic                   err_d;
  logic                   idx_ok, sel_done;
  logic [NUM_UNITS-1:0]   step_start_d;
  logic [7:0]             step_in_data_d, res_data_d;
  logic                   res_valid_d, res_err_d, busy_d, cmd_ready_d;

  // Program table; writes only land while idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) prog[i] <= '0;
    end else if (state == S_IDLE && prog_we) begin
      prog[prog_addr] <= prog_idx;
    end
  end

  // cur_idx is latched at issue so a same-cycle program write cannot retarget the wait
  assign idx_ok   = 32'(cur_idx) < NUM_UNITS;
  assign sel_done = idx_ok && step_done[cur_idx];

  always_comb begin
    state_d        = state;
    acc_d          = acc;
    len_d          = len;
    ptr_d          = ptr;
    cur_idx_d      = cur_idx;
    timer_d        = timer;
    err_d          = 1'b0;
    step_start_d   = '0;
    step_in_data_d = step_in_data;
    res_valid_d    = 1'b0;
    res_data_d     = res_data;
    res_err_d      = res_err;

    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          acc_d = cmd_data;
          len_d = (32'(cmd_len) > DEPTH) ? LEN_W'(DEPTH) : cmd_len;
          ptr_d = '0;
          state_d = (cmd_len == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        if (!idx_ok) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sel_done) begin
          acc_d = step_out_data[32'(cur_idx)*8 +: 8];
          ptr_d = ptr + ADDR_W'(1);
          state_d = (LEN_W'(ptr) + LEN_W'(1) == len) ? S_DONE : S_ISSUE;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          timer_d = timer + TMR_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Registered outputs are computed for the state being entered
    if (state_d == S_ISSUE) begin
      cur_idx_d      = prog[ptr_d];
      step_start_d   = NUM_UNITS'(1) << cur_idx_d;
      step_in_data_d = acc_d;
    end
    if (state_d == S_DONE) begin
      res_valid_d = 1'b1;
      res_data_d  = acc_d;
      res_err_d   = err_d;
    end
    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      acc          <= '0;
      len          <= '0;
      ptr          <= '0;
      cur_idx      <= '0;
      timer        <= '0;
      step_start   <= '0;
      step_in_data <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_err      <= 1'b0;
      busy         <= 1'b0;
      cmd_ready    <= 1'b1;
    end else begin
      state        <= state_d;
      acc          <= acc_d;
      len          <= len_d;
      ptr          <= ptr_d;
      cur_idx      <= cur_idx_d;
      timer        <= timer_d;
      step_start   <= step_start_d;
      step_in_data <= step_in_data_d;
      res_valid    <= res_valid_d;
      res_data     <= res_data_d;
      res_err      <= res_err_d;
      busy         <= busy_d;
      cmd_ready    <= cmd_ready_d;
    end
  end

`ifdef STEP_SEQ_PERF_EN
  // perf_cnt holds the cycle count since accept, inclusive of the current cycle
  logic [15:0] perf_cnt, perf_cnt_d;

  always_comb begin
    perf_cnt_d = perf_cnt;
    if (state == S_IDLE) begin
      if (cmd_valid) perf_cnt_d = 16'd2;
    end else if (perf_cnt != 16'hFFFF) begin
      perf_cnt_d = perf_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cnt    <= '0;
      perf_cycles <= '0;
    end else begin
      perf_cnt <= perf_cnt_d;
      if (state_d == S_DONE) perf_cycles <= perf_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer: behavioural step units plus a chain-level reference model.
module tb_step_sequencer;

  localparam int unsigned NU      = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned BUDGET  = 300;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [IDX_W-1:0]  prog_idx;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_data;
  logic [LEN_W-1:0]  cmd_len;
  logic [NU-1:0]     step_start;
  logic [7:0]        step_in_data;
  logic [NU-1:0]     step_done;
  logic [8*NU-1:0]   step_out_data;
  logic              res_valid;
  logic [7:0]        res_data;
  logic              res_err;
  logic              busy;
`ifdef STEP_SEQ_PERF_EN
  logic [15:0]       perf_cycles;
`endif

  int total = 0;
  int bad   = 0;

  // Unit configuration: latency 0 means the unit never signals done
  int unsigned   lat  [NU];
  logic [7:0]    addk [NU];
  logic [NU-1:0] stray;
  int unsigned   prog_m [DEPTH];

  // Reference model results
  logic [7:0]  exp_res;
  logic        exp_err;
  int unsigned exp_lat;
  int unsigned exp_si [$];
  int unsigned exp_sc [$];

  always #5 clk = ~clk;

  step_sequencer #(
    .NUM_UNITS(NU), .IDX_W(IDX_W), .DEPTH(DEPTH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_idx(prog_idx),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .step_start(step_start), .step_in_data(step_in_data),
    .step_done(step_done), .step_out_data(step_out_data),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err), .busy(busy)
`ifdef STEP_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  // Behavioural step units: add a constant, done lat cycles after the start cycle
  for (genvar g = 0; g < NU; g++) begin : g_unit
    int unsigned cnt = 0;
    logic        dn  = 1'b0;
    logic [7:0]  q   = 8'h00;
    logic [7:0]  opnd = 8'h00;
    assign step_done[g] = dn | stray[g];
    assign step_out_data[8*g +: 8] = q;
    always @(posedge clk) begin
      dn <= 1'b0;
      if (step_start[g]) begin
        if (lat[g] == 1) begin
          dn <= 1'b1;
          q  <= step_in_data + addk[g];
        end else if (lat[g] > 1) begin
          cnt  <= lat[g] - 1;
          opnd <= step_in_data;
        end
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          dn <= 1'b1;
          q  <= opnd + addk[g];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned oh_idx(input logic [NU-1:0] v);
    for (int i = 0; i < int'(NU); i++) if (v[i]) return i;
    return 99;
  endfunction

  // Chain result from the program table: sum of unit offsets, 2+ cycles per step
  function automatic void model(input logic [7:0] d, input int unsigned len);
    int unsigned n, u;
    logic [7:0]  a;
    n = (len > DEPTH) ? DEPTH : len;
    a = d;
    exp_err = 1'b0;
    exp_lat = 1;
    exp_si.delete();
    exp_sc.delete();
    for (int j = 0; j < int'(n); j++) begin
      u = prog_m[j];
      exp_si.push_back(u);
      exp_sc.push_back(exp_lat);
      if (lat[u] == 0) begin
        exp_lat += 1 + TIMEOUT;
        exp_err = 1'b1;
        break;
      end
      a = a + addk[u];
      exp_lat += 1 + lat[u];
    end
    exp_res = a;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, " step_start"},   32'(step_start),   0);
    check({tag, " step_in_data"}, 32'(step_in_data), 0);
    check({tag, " res_valid"},    32'(res_valid),    0);
    check({tag, " res_data"},     32'(res_data),     0);
    check({tag, " res_err"},      32'(res_err),      0);
    check({tag, " busy"},         32'(busy),         0);
    check({tag, " cmd_ready"},    32'(cmd_ready),    1);
  endtask

  task automatic write_prog(input int unsigned a, input int unsigned v);
    prog_we   = 1'b1;
    prog_addr = ADDR_W'(a);
    prog_idx  = IDX_W'(v);
    @(negedge clk);
    prog_we   = 1'b0;
    prog_m[a] = v;
  endtask

  // Issue one command from IDLE and check timing, start sequence and result
  task automatic run_cmd(input logic [7:0] d, input int unsigned len, input bit wr_same,
                         input bit inject, input string tag);
    int unsigned k;
    bit          got;
    logic [7:0]  held;
    int unsigned obs_i [$];
    int unsigned obs_c [$];
    int unsigned n;
    model(d, len);
    check({tag, " ready"}, 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_len   = LEN_W'(len);
    if (wr_same) begin
      prog_we   = 1'b1;
      prog_addr = '0;
      prog_idx  = IDX_W'((prog_m[0] + 1) % NU);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = 8'($urandom);
    if (wr_same) begin
      prog_we   = 1'b0;
      prog_m[0] = (prog_m[0] + 1) % NU;
    end
    check({tag, " busy"}, 32'(busy), 1);
    got = 1'b0;
    k = 1;
    while (!got && k < BUDGET) begin
      if (inject && k == 2) begin
        prog_we   = 1'b1;
        prog_addr = '0;
        prog_idx  = IDX_W'((prog_m[0] + 1) % NU);
        if (exp_si.size() > 0) stray = NU'(1) << ((exp_si[0] + 1) % NU);
      end else if (inject && k == 3) begin
        prog_we = 1'b0;
        stray   = '0;
      end
      if (step_start != '0) begin
        check({tag, " start onehot"}, 32'($countones(step_start)), 1);
        obs_i.push_back(oh_idx(step_start));
        obs_c.push_back(k);
      end
      if (res_valid) got = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    prog_we = 1'b0;
    stray   = '0;
    check({tag, " res seen"}, 32'(got), 1);
    if (got) begin
      check({tag, " latency"}, k, exp_lat);
      check({tag, " res_data"}, 32'(res_data), 32'(exp_res));
      check({tag, " res_err"},  32'(res_err),  32'(exp_err));
`ifdef STEP_SEQ_PERF_EN
      check({tag, " perf"}, 32'(perf_cycles), exp_lat + 1);
`endif
      check({tag, " starts"}, obs_i.size(), exp_si.size());
      n = (obs_i.size() < exp_si.size()) ? obs_i.size() : exp_si.size();
      for (int i = 0; i < int'(n); i++) begin
        check({tag, " start idx"}, obs_i[i], exp_si[i]);
        check({tag, " start cyc"}, obs_c[i], exp_sc[i]);
      end
      held = res_data;
      @(negedge clk);
      check({tag, " busy after"},  32'(busy),      0);
      check({tag, " ready after"}, 32'(cmd_ready), 1);
      check({tag, " valid pulse"}, 32'(res_valid), 0);
      check({tag, " data hold"},   32'(res_data),  32'(held));
    end
  endtask

  initial begin
    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_idx = '0;
    cmd_valid = 1'b0; cmd_data = '0; cmd_len = '0; stray = '0;
    addk[0] = 8'd3; addk[1] = 8'd5; addk[2] = 8'd7; addk[3] = 8'd11;
    lat[0] = 1; lat[1] = 1; lat[2] = 1; lat[3] = 2;
    for (int i = 0; i < int'(DEPTH); i++) prog_m[i] = 0;

    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Three +3 steps from 10
    write_prog(0, 0); write_prog(1, 0); write_prog(2, 0);
    run_cmd(8'd10, 3, 1'b0, 1'b0, "t1");

    // +5 then +3 from FD wraps to 05
    write_prog(0, 1); write_prog(1, 0);
    run_cmd(8'hFD, 2, 1'b0, 1'b0, "t2");

    // Unit 2 never completes: timeout, then a stray done while idle is ignored
    lat[2] = 0;
    write_prog(0, 2);
    run_cmd(8'd7, 1, 1'b0, 1'b0, "t3");
    stray = 4'b0100;
    @(negedge clk);
    stray = '0;
    repeat (3) begin
      @(negedge clk);
      check("t3 stray busy",  32'(busy),      0);
      check("t3 stray valid", 32'(res_valid), 0);
    end
    lat[2] = 1;

    // Zero-length command passes data straight through
    run_cmd(8'hA5, 0, 1'b0, 1'b0, "t4");

    // Reset in the middle of a WAIT
    lat[3] = 3;
    write_prog(0, 3);
    cmd_valid = 1'b1; cmd_data = 8'd99; cmd_len = LEN_W'(1);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("t5 busy pre", 32'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("t5 midreset");
    rst_n = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) prog_m[i] = 0;
    repeat (4) @(negedge clk);
    run_cmd(8'd20, 1, 1'b0, 1'b0, "t5");

    // Program write and foreign done while busy have no effect
    write_prog(1, 1);
    run_cmd(8'd30, 2, 1'b0, 1'b1, "t6");
    run_cmd(8'd40, 1, 1'b0, 1'b0, "t6b");

    // Write in the accept cycle: command uses the old entry
    run_cmd(8'd50, 1, 1'b1, 1'b0, "t7");
    run_cmd(8'd50, 1, 1'b0, 1'b0, "t7b");

    // Length above DEPTH clamps to DEPTH
    for (int i = 0; i < int'(DEPTH); i++) write_prog(i, 0);
    run_cmd(8'd0, 15, 1'b0, 1'b0, "t8");

    // Randomized programs, latencies, operands and lengths
    for (int it = 0; it < 40; it++) begin
      for (int u = 0; u < int'(NU); u++)
        lat[u] = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
      for (int i = 0; i < int'(DEPTH); i++) write_prog(i, $urandom_range(0, NU - 1));
      run_cmd(8'($urandom), $urandom_range(0, 10), 1'b0, 1'b0, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
